vote_tally: RTL and testbench
=============================

// Module: vote_tally
// PURPOSE
// - Upstream of the seven-segment vote display: turns voter button presses into committed, region-tagged votes.
// - Maintains the 12 vote counters the display consumes: A/B/total, nationally and per region DC, MD, VA.
// - Synchronises and edge-detects raw buttons and switches.
// - Runs a select -> confirm -> lockout voting FSM and saturates counts at the display's 7-digit limit.
// PARAMETERS
// - CNT_W           29        counter width; matches display inputs
// - MAX_COUNT       9999999   saturation value, the largest value the 7-digit display can show
// - ARM_TIMEOUT     2000      clk cycles allowed between selection and confirm
// - LOCKOUT_CYCLES  500       clk cycles after a commit during which all presses are ignored
// PORTS
// - clk               in   1      system clock, rising edge
// - rst_n             in   1      asynchronous, active-low reset
// - btn_A             in   1      raw candidate-A button (async)
// - btn_B             in   1      raw candidate-B button (async)
// - btn_confirm       in   1      raw confirm button (async)
// - DC_sel            in   1      region switches (async); exactly one high = valid region
// - MD_sel            in   1      region switch, as DC_sel
// - VA_sel            in   1      region switch, as DC_sel
// - clear_votes       in   1      synchronous request to zero all counters
// - counter_{A,B,total}, counter_{DC,MD,VA}_{A,B,total}   out  CNT_W each   vote counts to display
// - vote_accepted     out  1      1-cycle pulse when a vote is committed
// - vote_rejected     out  1      1-cycle pulse on timeout, invalid region or saturation
// - busy              out  1      high in every state except IDLE
// BEHAVIOUR
// - Reset: all counters 0, FSM in IDLE, pulses 0, busy 0, synchroniser flops 0. Reset is honoured mid-operation with no partial commit.
// - Inputs: every button and switch passes a 2-flop synchroniser. Buttons also get rising-edge detection, which adds 3 cycles from the pin to the event.
// - IDLE
//   - Exactly one of A/B rises: latch the choice, clear the timer, go to ARMED.
//   - A and B rise in the same cycle: ignore both.
//   - Confirm rise: ignore.
//   - clear_votes high: zero all 12 counters next cycle. clear_votes is honoured only in IDLE.
// - ARMED
//   - Rise of the other candidate button: change the choice and restart the timer.
//   - Simultaneous A and B rise: ignore.
//   - Confirm rise: go to COMMIT.
//   - Timer reaches ARM_TIMEOUT-1: pulse vote_rejected, go to IDLE.
// - COMMIT (1 cycle)
//   - Sample the synchronised region switches.
//   - Accept only if exactly one region switch is high AND counter_total < MAX_COUNT.
//   - On accept, on the next edge:
//     - increment counter_<choice>, counter_total, counter_<rgn>_<choice> and counter_<rgn>_total;
//     - pulse vote_accepted;
//     - go to LOCKOUT.
//   - Otherwise: pulse vote_rejected and go to IDLE; no counter changes.
// - LOCKOUT: ignore all presses; after LOCKOUT_CYCLES cycles go to IDLE.
// - Invariants, which hold in every cycle:
//   - counter_A = DC_A + MD_A + VA_A, and likewise for B;
//   - every *_total = its *_A + *_B;
//   - no counter exceeds MAX_COUNT.
//   - The single check on counter_total is sufficient because counter_total bounds all other counters.
// - Outputs are registered; counters update 1 cycle after COMMIT; pulses align with the counter update.
// - Timer width: $clog2(max(ARM_TIMEOUT, LOCKOUT_CYCLES)+1). A single timer is shared by ARMED and LOCKOUT.
// STRUCTURE
// - Package evm_pkg holds:
//   - CNT_W, MAX_COUNT;
//   - region encoding TOTAL=2'b00, DC=2'b01, MD=2'b10, VA=2'b11, shared with the display;
//   - FSM state typedef {IDLE, ARMED, COMMIT, LOCKOUT};
//   - candidate enum {CAND_A, CAND_B}.
// - Sub-module evm_input_sync: per-bit 2-flop synchroniser plus rising-edge pulse. It is instantiated for the 3 buttons; switches use its level output only.
// - Counter bank: one generate loop over 3 regions x {A,B}. Totals are registered sums updated in the same cycle as their components, not combinational adders.
// TESTING
// 1. A press, 10 clk later confirm, DC_sel=1
//    -> after 1 cycle: counter_A = counter_DC_A = 1, counter_total = counter_DC_total = 1, vote_accepted 1 cycle; others 0.
// 2. B press then confirm with MD_sel=VA_sel=1
//    -> vote_rejected pulse; all counters unchanged.
// 3. A press, no confirm for ARM_TIMEOUT cycles
//    -> vote_rejected at cycle ARM_TIMEOUT; a confirm afterwards is ignored.
// 4. Commit vote, then A and confirm within LOCKOUT_CYCLES
//    -> no count change. Repeat after the lockout -> count = 2.
// 5. Force counter_total = 9999999 via a VA vote sequence (or a bench preload)
//    -> next vote is rejected; counters stay at MAX.
// 6. Assert rst_n low while in ARMED and while in COMMIT
//    -> all outputs 0 and state IDLE. clear_votes in IDLE zeroes counts; clear_votes in ARMED is ignored.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared types and limits for the vote tally and the seven-segment display.
// Region encoding is consumed by the display, so its values are fixed.
package evm_pkg;

  localparam int unsigned CNT_W          = 29;
  localparam int unsigned MAX_COUNT      = 9999999;
  localparam int unsigned ARM_TIMEOUT    = 2000;
  localparam int unsigned LOCKOUT_CYCLES = 500;

  typedef enum logic [1:0] {
    TOTAL = 2'b00,
    DC    = 2'b01,
    MD    = 2'b10,
    VA    = 2'b11
  } region_e;

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT, LOCKOUT} state_e;

  typedef enum logic {CAND_A, CAND_B} cand_e;

  // sw = {VA, MD, DC}; anything other than exactly one switch decodes to TOTAL (invalid)
  function automatic region_e region_decode(input logic [2:0] sw);
    case (sw)
      3'b001:  region_decode = DC;
      3'b010:  region_decode = MD;
      3'b100:  region_decode = VA;
      default: region_decode = TOTAL;
    endcase
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    max_u = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/evm_input_sync.sv
// Two-flop synchroniser for raw pins; buttons additionally get a registered
// rising-edge pulse (pin to pulse: 3 cycles), switches expose the level only.
module evm_input_sync #(
  parameter int NB = 3,
  parameter int NS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NB-1:0] btn_i,
  input  logic [NS-1:0] sw_i,
  output logic [NB-1:0] btn_rise_o,
  output logic [NS-1:0] sw_lvl_o
);

  logic [NB+NS-1:0] meta_q, sync_q;
  logic [NB-1:0]    prev_q, rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      meta_q <= {sw_i, btn_i};
      sync_q <= meta_q;
      prev_q <= sync_q[NB-1:0];
      rise_q <= sync_q[NB-1:0] & ~prev_q;
    end
  end

  assign btn_rise_o = rise_q;
  assign sw_lvl_o   = sync_q[NB+NS-1:NB];

endmodule

// File: rtl/vote_tally.sv
// Turns button presses into committed, region-tagged votes and keeps the 12
// display counters; select -> confirm -> lockout FSM with saturation at MAX_COUNT.
module vote_tally #(
  parameter int unsigned MAX_COUNT      = evm_pkg::MAX_COUNT,
  parameter int unsigned ARM_TIMEOUT    = evm_pkg::ARM_TIMEOUT,
  parameter int unsigned LOCKOUT_CYCLES = evm_pkg::LOCKOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      btn_A,
  input  logic                      btn_B,
  input  logic                      btn_confirm,
  input  logic                      DC_sel,
  input  logic                      MD_sel,
  input  logic                      VA_sel,
  input  logic                      clear_votes,
  output logic [evm_pkg::CNT_W-1:0] counter_A,
  output logic [evm_pkg::CNT_W-1:0] counter_B,
  output logic [evm_pkg::CNT_W-1:0] counter_total,
  output logic [evm_pkg::CNT_W-1:0] counter_DC_A,
  output logic [evm_pkg::CNT_W-1:0] counter_DC_B,
  output logic [evm_pkg::CNT_W-1:0] counter_DC_total,
  output logic [evm_pkg::CNT_W-1:0] counter_MD_A,
  output logic [evm_pkg::CNT_W-1:0] counter_MD_B,
  output logic [evm_pkg::CNT_W-1:0] counter_MD_total,
  output logic [evm_pkg::CNT_W-1:0] counter_VA_A,
  output logic [evm_pkg::CNT_W-1:0] counter_VA_B,
  output logic [evm_pkg::CNT_W-1:0] counter_VA_total,
  output logic                      vote_accepted,
  output logic                      vote_rejected,
  output logic                      busy
);
  import evm_pkg::*;

  localparam int          TMR_W     = $clog2(evm_pkg::max_u(ARM_TIMEOUT, LOCKOUT_CYCLES) + 1);
  localparam logic [TMR_W-1:0] ARM_LAST  = TMR_W'(ARM_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);

  logic [2:0] btn_rise, sw_lvl;
  logic       rise_a, rise_b, rise_c, one_cand;

  evm_input_sync #(.NB(3), .NS(3)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_i      ({btn_confirm, btn_B, btn_A}),
    .sw_i       ({VA_sel, MD_sel, DC_sel}),
    .btn_rise_o (btn_rise),
    .sw_lvl_o   (sw_lvl)
  );

  assign rise_a   = btn_rise[0];
  assign rise_b   = btn_rise[1];
  assign rise_c   = btn_rise[2];
  assign one_cand = rise_a ^ rise_b;

  state_e            state_q;
  cand_e             choice_q;
  logic [TMR_W-1:0]  timer_q;
  logic              acc_q, rej_q, busy_q;
  logic [CNT_W-1:0]  total_q;
  region_e           rgn;
  logic              accept, commit_en, clr;

  assign rgn       = region_decode(sw_lvl);
  // total bounds every other counter, so this one compare guards them all
  assign accept    = (rgn != TOTAL) && (total_q < CNT_W'(MAX_COUNT));
  assign commit_en = (state_q == COMMIT) && accept;
  assign clr       = (state_q == IDLE) && clear_votes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      choice_q <= CAND_A;
      timer_q  <= '0;
      acc_q    <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      acc_q <= 1'b0;
      rej_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (one_cand) begin
            choice_q <= rise_a ? CAND_A : CAND_B;
            timer_q  <= '0;
            state_q  <= ARMED;
            busy_q   <= 1'b1;
          end
        end
        ARMED: begin
          if (rise_c) begin
            state_q <= COMMIT;
          end else if (one_cand && ((rise_a ? CAND_A : CAND_B) != choice_q)) begin
            choice_q <= rise_a ? CAND_A : CAND_B;
            timer_q  <= '0;
          end else if (timer_q == ARM_LAST) begin
            rej_q   <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        COMMIT: begin
          if (accept) begin
            acc_q   <= 1'b1;
            timer_q <= '0;
            state_q <= LOCKOUT;
          end else begin
            rej_q   <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (timer_q == LOCK_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [2:0][1:0][CNT_W-1:0] rgn_cnt;
  logic [2:0][CNT_W-1:0]      rgn_tot;
  logic [1:0][CNT_W-1:0]      nat_cnt;

  for (genvar r = 0; r < 3; r++) begin : g_rgn
    logic             hit;
    logic [CNT_W-1:0] tot_q;
    assign hit = commit_en && (rgn == region_e'(2'(r + 1)));

    for (genvar c = 0; c < 2; c++) begin : g_cand
      logic [CNT_W-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   cnt_q <= '0;
        else if (clr)                                 cnt_q <= '0;
        else if (hit && (choice_q == cand_e'(1'(c)))) cnt_q <= cnt_q + 1'b1;
      end
      assign rgn_cnt[r][c] = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   tot_q <= '0;
      else if (clr) tot_q <= '0;
      else if (hit) tot_q <= tot_q + 1'b1;
    end
    assign rgn_tot[r] = tot_q;
  end

  for (genvar c = 0; c < 2; c++) begin : g_nat
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                         cnt_q <= '0;
      else if (clr)                                       cnt_q <= '0;
      else if (commit_en && (choice_q == cand_e'(1'(c)))) cnt_q <= cnt_q + 1'b1;
    end
    assign nat_cnt[c] = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         total_q <= '0;
    else if (clr)       total_q <= '0;
    else if (commit_en) total_q <= total_q + 1'b1;
  end

  assign counter_A        = nat_cnt[0];
  assign counter_B        = nat_cnt[1];
  assign counter_total    = total_q;
  assign counter_DC_A     = rgn_cnt[0][0];
  assign counter_DC_B     = rgn_cnt[0][1];
  assign counter_DC_total = rgn_tot[0];
  assign counter_MD_A     = rgn_cnt[1][0];
  assign counter_MD_B     = rgn_cnt[1][1];
  assign counter_MD_total = rgn_tot[1];
  assign counter_VA_A     = rgn_cnt[2][0];
  assign counter_VA_B     = rgn_cnt[2][1];
  assign counter_VA_total = rgn_tot[2];
  assign vote_accepted    = acc_q;
  assign vote_rejected    = rej_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_vote_tally.sv
// Scoreboard bench for vote_tally with short timeouts and a small saturation limit.
`timescale 1ns/1ps
module tb_vote_tally;

  localparam int unsigned T_MAX  = 3;
  localparam int unsigned T_ARM  = 40;
  localparam int unsigned T_LOCK = 20;
  localparam int          CW     = 29;

  typedef struct packed {
    logic             acc;
    logic [5:0][31:0] rc;
  } exp_t;

  logic clk, rst_n;
  logic btn_A, btn_B, btn_confirm, DC_sel, MD_sel, VA_sel, clear_votes;
  logic [CW-1:0] counter_A, counter_B, counter_total;
  logic [CW-1:0] counter_DC_A, counter_DC_B, counter_DC_total;
  logic [CW-1:0] counter_MD_A, counter_MD_B, counter_MD_total;
  logic [CW-1:0] counter_VA_A, counter_VA_B, counter_VA_total;
  logic vote_accepted, vote_rejected, busy;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic [5:0][31:0] m_rc;   // index region*2 + cand, region DC=0 MD=1 VA=2

  vote_tally #(.MAX_COUNT(T_MAX), .ARM_TIMEOUT(T_ARM), .LOCKOUT_CYCLES(T_LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .btn_A(btn_A), .btn_B(btn_B), .btn_confirm(btn_confirm),
    .DC_sel(DC_sel), .MD_sel(MD_sel), .VA_sel(VA_sel), .clear_votes(clear_votes),
    .counter_A(counter_A), .counter_B(counter_B), .counter_total(counter_total),
    .counter_DC_A(counter_DC_A), .counter_DC_B(counter_DC_B), .counter_DC_total(counter_DC_total),
    .counter_MD_A(counter_MD_A), .counter_MD_B(counter_MD_B), .counter_MD_total(counter_MD_total),
    .counter_VA_A(counter_VA_A), .counter_VA_B(counter_VA_B), .counter_VA_total(counter_VA_total),
    .vote_accepted(vote_accepted), .vote_rejected(vote_rejected), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_counts(input string pfx, input logic [5:0][31:0] rc);
    chk({pfx, "_A"},        32'(counter_A),        rc[0] + rc[2] + rc[4]);
    chk({pfx, "_B"},        32'(counter_B),        rc[1] + rc[3] + rc[5]);
    chk({pfx, "_total"},    32'(counter_total),    rc[0] + rc[1] + rc[2] + rc[3] + rc[4] + rc[5]);
    chk({pfx, "_DC_A"},     32'(counter_DC_A),     rc[0]);
    chk({pfx, "_DC_B"},     32'(counter_DC_B),     rc[1]);
    chk({pfx, "_DC_total"}, 32'(counter_DC_total), rc[0] + rc[1]);
    chk({pfx, "_MD_A"},     32'(counter_MD_A),     rc[2]);
    chk({pfx, "_MD_B"},     32'(counter_MD_B),     rc[3]);
    chk({pfx, "_MD_total"}, 32'(counter_MD_total), rc[2] + rc[3]);
    chk({pfx, "_VA_A"},     32'(counter_VA_A),     rc[4]);
    chk({pfx, "_VA_B"},     32'(counter_VA_B),     rc[5]);
    chk({pfx, "_VA_total"}, 32'(counter_VA_total), rc[4] + rc[5]);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 = A, 1 = B, otherwise confirm
  task automatic press(input int which);
    case (which)
      0:       btn_A = 1'b1;
      1:       btn_B = 1'b1;
      default: btn_confirm = 1'b1;
    endcase
    tick(2);
    btn_A = 1'b0; btn_B = 1'b0; btn_confirm = 1'b0;
    tick(1);
  endtask

  task automatic push(input logic acc);
    exp_t e;
    e.acc = acc;
    e.rc  = m_rc;
    sb_q.push_back(e);
  endtask

  task automatic wait_pulse(input string tag);
    int n = 0;
    while (!(vote_accepted || vote_rejected) && n < 100) begin tick(1); n++; end
    chk({tag, "_pulse_seen"}, 32'(n < 100), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin tick(1); n++; end
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  // sw = {VA, MD, DC}
  task automatic vote(input int cand, input logic [2:0] sw, input logic acc, input string tag);
    int r;
    {VA_sel, MD_sel, DC_sel} = sw;
    tick(3);
    press(cand);
    tick(6);
    r = sw[0] ? 0 : (sw[1] ? 1 : 2);
    if (acc) m_rc[r*2 + cand] = m_rc[r*2 + cand] + 1;
    push(acc);
    press(2);
    wait_pulse(tag);
    wait_idle(tag);
  endtask

  // Scoreboard consumer: every accept/reject pulse pops one expectation.
  initial begin
    logic prev, pulse;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      pulse = vote_accepted | vote_rejected;
      if (pulse) begin
        chk("pulse_width", 32'(prev), 0);
        chk("pulse_both", 32'(vote_accepted & vote_rejected), 0);
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", 32'(pulse), 0);
        end else begin
          e = sb_q.pop_front();
          chk("pulse_kind", 32'(vote_accepted), 32'(e.acc));
          check_counts("sb", e.rc);
        end
      end
      prev = pulse;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    btn_A = 0; btn_B = 0; btn_confirm = 0;
    DC_sel = 0; MD_sel = 0; VA_sel = 0; clear_votes = 0;
    rst_n = 0; m_rc = '0;
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_acc", 32'(vote_accepted), 0);
    chk("rst_rej", 32'(vote_rejected), 0);
    check_counts("rst", m_rc);
    rst_n = 1;
    tick(2);

    // 1: A vote in DC, with pin-to-ARMED latency and lockout length
    btn_A = 1'b1;
    n = 0;
    while (!busy && n < 20) begin tick(1); n++; end
    chk("arm_latency", 32'(n), 4);
    btn_A = 1'b0;
    DC_sel = 1'b1;
    tick(10);
    m_rc[0] = m_rc[0] + 1;
    push(1'b1);
    press(2);
    wait_pulse("t1");
    n = 0;
    while (busy && n < 100) begin tick(1); n++; end
    chk("lockout_cycles", 32'(n), T_LOCK);

    // 2: two region switches high
    vote(1, 3'b110, 1'b0, "t2");

    // 3: arm timeout, then a stray confirm in IDLE
    {VA_sel, MD_sel, DC_sel} = 3'b000;
    push(1'b0);
    press(0);
    n = 0;
    while (!busy && n < 20) begin tick(1); n++; end
    n = 0;
    while (!vote_rejected && n < 200) begin tick(1); n++; end
    chk("timeout_cycles", 32'(n), T_ARM);
    tick(2);
    press(2);
    tick(10);
    chk("t3_confirm_ignored_busy", 32'(busy), 0);
    check_counts("t3", m_rc);

    // 4: change of choice A->B in VA, presses during lockout ignored
    VA_sel = 1'b1;
    tick(3);
    press(0);
    tick(4);
    press(1);
    tick(6);
    m_rc[5] = m_rc[5] + 1;
    push(1'b1);
    press(2);
    wait_pulse("t4");
    press(0);
    press(2);
    wait_idle("t4");
    tick(5);
    check_counts("t4_lock", m_rc);
    chk("t4_sb_empty", 32'(sb_q.size()), 0);
    vote(0, 3'b010, 1'b1, "t4b");

    // 5: total is at MAX, next vote saturates
    vote(0, 3'b001, 1'b0, "t5");
    chk("sat_total", 32'(counter_total), T_MAX);

    // 6: clear in ARMED ignored, clear in IDLE zeroes
    press(0);
    tick(6);
    chk("clr_armed_busy", 32'(busy), 1);
    clear_votes = 1'b1;
    tick(1);
    clear_votes = 1'b0;
    tick(2);
    check_counts("clr_armed", m_rc);
    push(1'b0);
    wait_pulse("clr_to");
    wait_idle("clr_to");
    clear_votes = 1'b1;
    tick(1);
    clear_votes = 1'b0;
    tick(1);
    m_rc = '0;
    check_counts("clr_idle", m_rc);

    // simultaneous A and B in IDLE
    btn_A = 1'b1; btn_B = 1'b1;
    tick(2);
    btn_A = 1'b0; btn_B = 1'b0;
    tick(6);
    chk("ab_same_busy", 32'(busy), 0);

    vote(0, 3'b001, 1'b1, "t6v");

    // reset while ARMED
    press(0);
    tick(3);
    chk("armed_busy", 32'(busy), 1);
    rst_n = 1'b0;
    tick(1);
    m_rc = '0;
    chk("rst_armed_busy", 32'(busy), 0);
    check_counts("rst_armed", m_rc);
    rst_n = 1'b1;
    tick(2);

    // reset while in COMMIT (4 edges after the confirm pin rises)
    DC_sel = 1'b1;
    tick(3);
    press(1);
    tick(6);
    btn_confirm = 1'b1;
    tick(2);
    btn_confirm = 1'b0;
    tick(2);
    chk("commit_busy", 32'(busy), 1);
    rst_n = 1'b0;
    tick(1);
    chk("rst_commit_acc", 32'(vote_accepted), 0);
    rst_n = 1'b1;
    tick(30);
    check_counts("rst_commit", m_rc);
    chk("rst_commit_busy", 32'(busy), 0);
    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
